// File: rtl/mux_pkg.sv
// Shared constants and helpers for the gates/mux library.
// Mode encodings plus a clog2 that never collapses to a zero-width vector.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell timer for scan mode: counts enabled edges and ticks on the last
// cycle of each dwell period. clr forces the count back to zero.
module scan_timer
  import mux_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = clog2_min1(DWELL);
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (clr_i || (cnt_q == CntLast)) cnt_d = '0;
      else                             cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == CntLast);

endmodule

// File: rtl/mux_scan_n.sv
// N-channel registered multiplexer with manual select and round-robin scan.
// scan_ch tracks the manual select so a switch to scan resumes from it.
module mux_scan_n
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 4,
  localparam int unsigned SEL_W   = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      mode_i,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic [CHANNELS*WIDTH-1:0] d_i,
  output logic [WIDTH-1:0]          y_o,
  output logic [SEL_W-1:0]          ch_o,
  output logic                      valid_o,
  output logic                      wrap_o
);

  localparam logic [SEL_W-1:0] LastCh = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] scan_ch_q, scan_ch_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic             sel_legal;
  logic [WIDTH-1:0] man_data, scan_data;

  scan_timer #(
    .DWELL (DWELL)
  ) u_scan_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en_i),
    .clr_i  (mode_i == MODE_MANUAL),
    .tick_o (tick)
  );

  assign sel_legal = (32'(sel_i) < CHANNELS);

  // Out-of-range selects fall through to zero.
  always_comb begin
    man_data  = '0;
    scan_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (sel_i == SEL_W'(k))     man_data  = d_i[k*WIDTH +: WIDTH];
      if (scan_ch_q == SEL_W'(k)) scan_data = d_i[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    y_d       = y_q;
    ch_d      = ch_q;
    scan_ch_d = scan_ch_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    if (en_i) begin
      if (mode_i == MODE_MANUAL) begin
        y_d       = man_data;
        ch_d      = sel_i;
        valid_d   = sel_legal;
        scan_ch_d = sel_legal ? sel_i : '0;
      end else begin
        y_d     = scan_data;
        ch_d    = scan_ch_q;
        valid_d = 1'b1;
        if (tick) begin
          scan_ch_d = (scan_ch_q == LastCh) ? '0 : scan_ch_q + 1'b1;
          wrap_d    = (scan_ch_q == LastCh);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      ch_q      <= '0;
      scan_ch_q <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      y_q       <= y_d;
      ch_q      <= ch_d;
      scan_ch_q <= scan_ch_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
    end
  end

  assign y_o     = y_q;
  assign ch_o    = ch_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench: a 4-channel and a 3-channel instance, both 8-bit, DWELL=2.
module tb_mux_scan_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        en_a = 1'b0, mode_a = 1'b0;
  logic [1:0]  sel_a = '0;
  logic [31:0] d_a = 32'h44332211;
  logic [7:0]  y_a;
  logic [1:0]  ch_a;
  logic        valid_a, wrap_a;

  logic        en_b = 1'b0, mode_b = 1'b0;
  logic [1:0]  sel_b = '0;
  logic [23:0] d_b = 24'h332211;
  logic [7:0]  y_b;
  logic [1:0]  ch_b;
  logic        valid_b, wrap_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mux_scan_n #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en_a), .mode_i(mode_a), .sel_i(sel_a),
    .d_i(d_a), .y_o(y_a), .ch_o(ch_a), .valid_o(valid_a), .wrap_o(wrap_a)
  );

  mux_scan_n #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en_b), .mode_i(mode_b), .sel_i(sel_b),
    .d_i(d_b), .y_o(y_b), .ch_o(ch_b), .valid_o(valid_b), .wrap_o(wrap_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with the given inputs applied, released between edges.
  task automatic do_reset(input logic en, input logic mode, input logic [1:0] sel);
    rst_n = 1'b0;
    step();
    en_a = en; mode_a = mode; sel_a = sel;
    en_b = 1'b0; mode_b = 1'b0; sel_b = '0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_a = 1'b1; mode_a = 1'b1;
    #2;
    total++;
    if ({y_a, ch_a, valid_a, wrap_a} !== 12'h000) begin
      bad++;
      $display("FAIL reset_a: got y=%h ch=%0d v=%b w=%b want all zero", y_a, ch_a, valid_a, wrap_a);
    end
    total++;
    if ({y_b, ch_b, valid_b, wrap_b} !== 12'h000) begin
      bad++;
      $display("FAIL reset_b: got y=%h ch=%0d v=%b w=%b want all zero", y_b, ch_b, valid_b, wrap_b);
    end
  endtask

  task automatic test_manual();
    do_reset(1'b1, 1'b0, 2'd2);
    step();
    total++;
    if ({y_a, ch_a, valid_a, wrap_a} !== {8'h33, 2'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL manual_sel2: got y=%h ch=%0d v=%b w=%b want y=33 ch=2 v=1 w=0",
               y_a, ch_a, valid_a, wrap_a);
    end
    sel_a = 2'd0;
    step();
    total++;
    if ({y_a, ch_a, valid_a} !== {8'h11, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL manual_sel0: got y=%h ch=%0d v=%b want y=11 ch=0 v=1", y_a, ch_a, valid_a);
    end
  endtask

  task automatic test_scan_sweep();
    logic [1:0] exp_ch [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [7:0] exp_y;
    do_reset(1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      exp_y = 8'h11 * ({6'd0, exp_ch[i]} + 8'd1);
      total++;
      if ({y_a, ch_a, valid_a, wrap_a} !== {exp_y, exp_ch[i], 1'b1, (i == 7)}) begin
        bad++;
        $display("FAIL sweep[%0d]: got y=%h ch=%0d v=%b w=%b want y=%h ch=%0d v=1 w=%b",
                 i, y_a, ch_a, valid_a, wrap_a, exp_y, exp_ch[i], (i == 7));
      end
    end
  endtask

  task automatic test_enable_hold();
    do_reset(1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 3; i++) step();
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({y_a, ch_a, valid_a, wrap_a} !== {8'h22, 2'd1, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL hold[%0d]: got y=%h ch=%0d v=%b w=%b want y=22 ch=1 v=0 w=0",
                 i, y_a, ch_a, valid_a, wrap_a);
      end
    end
    en_a = 1'b1;
    step();
    total++;
    if ({ch_a, valid_a} !== {2'd1, 1'b1}) begin
      bad++;
      $display("FAIL hold_resume1: got ch=%0d v=%b want ch=1 v=1", ch_a, valid_a);
    end
    step();
    total++;
    if ({y_a, ch_a} !== {8'h33, 2'd2}) begin
      bad++;
      $display("FAIL hold_resume2: got y=%h ch=%0d want y=33 ch=2", y_a, ch_a);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 7; i++) step();
    total++;
    if (ch_a !== 2'd3) begin
      bad++;
      $display("FAIL areset_pre: got ch=%0d want 3", ch_a);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({y_a, ch_a, valid_a, wrap_a} !== 12'h000) begin
      bad++;
      $display("FAIL areset_now: got y=%h ch=%0d v=%b w=%b want all zero", y_a, ch_a, valid_a, wrap_a);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (ch_a !== ((i < 2) ? 2'd0 : 2'd1)) begin
        bad++;
        $display("FAIL areset_restart[%0d]: got ch=%0d want %0d", i, ch_a, (i < 2) ? 0 : 1);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] exp_ch [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    do_reset(1'b0, 1'b0, 2'd0);
    en_b = 1'b1; mode_b = 1'b0; sel_b = 2'd3;
    step();
    total++;
    if ({y_b, ch_b, valid_b, wrap_b} !== {8'h00, 2'd3, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL oor_sel3: got y=%h ch=%0d v=%b w=%b want y=00 ch=3 v=0 w=0",
               y_b, ch_b, valid_b, wrap_b);
    end
    mode_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if ({y_b, ch_b, valid_b, wrap_b} !==
          {8'h11 * ({6'd0, exp_ch[i]} + 8'd1), exp_ch[i], 1'b1, (i == 5)}) begin
        bad++;
        $display("FAIL oor_scan[%0d]: got y=%h ch=%0d v=%b w=%b want ch=%0d w=%b",
                 i, y_b, ch_b, valid_b, wrap_b, exp_ch[i], (i == 5));
      end
    end
  endtask

  task automatic test_mode_handover();
    logic [1:0] exp_ch [3] = '{2'd3, 2'd3, 2'd0};
    do_reset(1'b1, 1'b0, 2'd3);
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({y_a, ch_a, valid_a, wrap_a} !== {8'h44, 2'd3, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL handover_man[%0d]: got y=%h ch=%0d v=%b w=%b want y=44 ch=3 v=1 w=0",
                 i, y_a, ch_a, valid_a, wrap_a);
      end
    end
    mode_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({ch_a, wrap_a} !== {exp_ch[i], (i == 1)}) begin
        bad++;
        $display("FAIL handover_scan[%0d]: got ch=%0d w=%b want ch=%0d w=%b",
                 i, ch_a, wrap_a, exp_ch[i], (i == 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_sweep();
    test_enable_hold();
    test_async_reset();
    test_out_of_range();
    test_mode_handover();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
